// File: rtl/long_string_renderer.sv
// Renders one 72-pixel-wide bitmap string box. Each line fetches one ROM row
// ahead of X_POS, then shifts it out one pixel per clock.
module long_string_renderer #(
  parameter int X_POS      = 100,
  parameter int Y_POS      = 50,
  parameter int BASE_ADDR  = 0,
  parameter int ROWS       = 16,
  parameter int FETCH_LEAD = 4
) (
  input  logic        VGA_CLK,
  input  logic        Reset,
  input  logic        Enable,
  input  logic [10:0] H_Count,
  input  logic [10:0] V_Count,
  output logic [4:0]  String_Address,
  input  logic [71:0] String_Data,
  output logic        Pixel_On,
  output logic        Busy
);

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, ARMED, SHIFT} state_t;

  localparam logic [10:0] TRIG_H = 11'(X_POS - FETCH_LEAD);
  localparam logic [10:0] LAST_H = 11'(X_POS - 1);
  localparam logic [10:0] Y_TOP  = 11'(Y_POS);
  localparam logic [10:0] Y_END  = 11'(Y_POS + ROWS);
  localparam logic [6:0]  WIDTH  = 7'd72;

  state_t      state, state_n;
  logic [4:0]  addr_n;
  logic [71:0] sr, sr_n;
  logic [6:0]  cnt, cnt_n;
  logic        pix_n;
  logic        in_win, trig;
  logic [4:0]  row_addr;

  assign in_win   = (V_Count >= Y_TOP) && (V_Count < Y_END);
  assign trig     = Enable && (H_Count == TRIG_H) && in_win;
  // Only the low 5 bits matter since the address wraps modulo 32.
  assign row_addr = V_Count[4:0] - 5'(Y_POS) + 5'(BASE_ADDR);
  assign Busy     = (state != IDLE);

  always_ff @(posedge VGA_CLK) begin
    if (Reset) begin
      state          <= IDLE;
      String_Address <= 5'd0;
      sr             <= '0;
      cnt            <= 7'd0;
      Pixel_On       <= 1'b0;
    end else begin
      state          <= state_n;
      String_Address <= addr_n;
      sr             <= sr_n;
      cnt            <= cnt_n;
      Pixel_On       <= pix_n;
    end
  end

  always_comb begin
    state_n = state;
    addr_n  = String_Address;
    sr_n    = sr;
    cnt_n   = cnt;
    pix_n   = 1'b0;
    if (!Enable) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:
          if (trig) begin
            addr_n  = row_addr;
            state_n = FETCH;
          end
        FETCH: state_n = LATCH;
        // With the minimum lead the row is latched on the X_POS-1 edge itself.
        LATCH: begin
          sr_n    = String_Data;
          cnt_n   = 7'd0;
          state_n = (H_Count == LAST_H) ? SHIFT : ARMED;
        end
        ARMED:
          if (H_Count == LAST_H) begin
            cnt_n   = 7'd0;
            state_n = SHIFT;
          end
        SHIFT:
          if (cnt == WIDTH) begin
            state_n = IDLE;
          end else begin
            pix_n = sr[71];
            sr_n  = {sr[70:0], 1'b0};
            cnt_n = cnt + 7'd1;
          end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule
